// File: rtl/card_dispatcher_pkg.sv
// Shared types and constants for the card dispatcher: FSM states, destination codes and deck defaults.
package card_dispatcher_pkg;

   localparam int DECK_SIZE_DEF = 52;
   localparam int ADDR_W_DEF    = 6;

   localparam logic DEST_PLAYER = 1'b0;
   localparam logic DEST_DEALER = 1'b1;

   typedef enum logic [2:0] {
      ST_SHUFFLE,
      ST_WAIT_SHUF,
      ST_IDLE,
      ST_READ,
      ST_RETURN
   } state_t;

endpackage

// File: rtl/card_dispatcher_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, priority moves past the winner on accept.
// Bit 0 is the player and bit 1 is the dealer; the player holds priority after reset.
module rr_arbiter2
   import card_dispatcher_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   logic prio;

   always_comb begin
      gnt = 2'b00;
      if (req[0] && req[1]) begin
         gnt = (prio == DEST_DEALER) ? 2'b10 : 2'b01;
      end else if (req[0]) begin
         gnt = 2'b01;
      end else if (req[1]) begin
         gnt = 2'b10;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio <= DEST_PLAYER;
      end else if (accept && (gnt != 2'b00)) begin
         prio <= gnt[0] ? DEST_DEALER : DEST_PLAYER;
      end
   end

endmodule

// File: rtl/card_dispatcher.sv
// Deals cards from a shuffled deck memory to player/dealer; card_valid 3 cycles after the IDLE grant.
// Requests are level-held and only sampled in IDLE; the deck is reshuffled after reset and on every wrap.
module card_dispatcher
   import card_dispatcher_pkg::*;
#(
   parameter int DECK_SIZE = DECK_SIZE_DEF,
   parameter int ADDR_W    = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_player,
   input  logic              req_dealer,
   input  logic              reshuffle,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [3:0]        mem_q,
   output logic              shuffle_start,
   input  logic              shuffle_done,
   output logic              card_valid,
   output logic [3:0]        card_value,
   output logic              card_dest,
   output logic              busy,
   output logic [ADDR_W-1:0] cards_left
);

   // One extra bit so the pointer can reach DECK_SIZE == 2**ADDR_W.
   localparam int PTR_W = ADDR_W + 1;

   state_t           state;
   state_t           state_nxt;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_inc;
   logic [PTR_W-1:0] left_full;
   logic             need_shuf;
   logic             grant_acc;
   logic [1:0]       gnt;

   rr_arbiter2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    ({req_dealer, req_player}),
      .accept (grant_acc),
      .gnt    (gnt)
   );

   assign ptr_inc    = ptr + PTR_W'(1);
   assign left_full  = PTR_W'(DECK_SIZE) - ptr;
   assign cards_left = left_full[ADDR_W-1:0];
   assign busy       = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Reset parks in IDLE with need_shuf set, so outputs read idle during reset and SHUFFLE follows release.
   always_comb begin
      state_nxt = state;
      grant_acc = 1'b0;
      case (state)
         ST_SHUFFLE:   state_nxt = ST_WAIT_SHUF;
         ST_WAIT_SHUF: if (shuffle_done) state_nxt = ST_IDLE;
         ST_IDLE: begin
            if (need_shuf || reshuffle) begin
               state_nxt = ST_SHUFFLE;
            end else if (req_player || req_dealer) begin
               state_nxt = ST_READ;
               grant_acc = 1'b1;
            end
         end
         ST_READ:      state_nxt = ST_RETURN;
         ST_RETURN:    state_nxt = (ptr_inc == PTR_W'(DECK_SIZE)) ? ST_SHUFFLE : ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         need_shuf     <= 1'b1;
         ptr           <= '0;
         mem_addr      <= '0;
         card_value    <= '0;
         card_dest     <= DEST_PLAYER;
         card_valid    <= 1'b0;
         shuffle_start <= 1'b0;
      end else begin
         card_valid    <= 1'b0;
         shuffle_start <= (state_nxt == ST_SHUFFLE);
         case (state)
            ST_SHUFFLE: begin
               ptr       <= '0;
               need_shuf <= 1'b0;
            end
            ST_IDLE: begin
               if (grant_acc) begin
                  mem_addr  <= ptr[ADDR_W-1:0];
                  card_dest <= gnt[1] ? DEST_DEALER : DEST_PLAYER;
               end
            end
            ST_RETURN: begin
               card_value <= mem_q;
               card_valid <= 1'b1;
               ptr        <= ptr_inc;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_card_dispatcher.sv
// Directed bench for card_dispatcher with a synchronous deck memory and a 5-cycle shuffle model.
module tb_card_dispatcher;
   import card_dispatcher_pkg::*;

   localparam int AW = ADDR_W_DEF;
   localparam int DS = DECK_SIZE_DEF;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_player = 1'b0;
   logic          req_dealer = 1'b0;
   logic          reshuffle = 1'b0;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_q = 4'd0;
   logic          shuffle_start;
   logic          shuffle_done = 1'b1;
   logic          card_valid;
   logic [3:0]    card_value;
   logic          card_dest;
   logic          busy;
   logic [AW-1:0] cards_left;

   logic [3:0] deck [64];
   int shuf_cnt = 0;
   int shuf_pulses = 0;
   int cv_pulses = 0;
   int vectors = 0;
   int miscompares = 0;

   card_dispatcher #(.DECK_SIZE(DS), .ADDR_W(AW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_player    (req_player),
      .req_dealer    (req_dealer),
      .reshuffle     (reshuffle),
      .mem_addr      (mem_addr),
      .mem_q         (mem_q),
      .shuffle_start (shuffle_start),
      .shuffle_done  (shuffle_done),
      .card_valid    (card_valid),
      .card_value    (card_value),
      .card_dest     (card_dest),
      .busy          (busy),
      .cards_left    (cards_left)
   );

   always #5 clk = ~clk;

   // Deck memory and shuffler: done drops on the edge that sees shuffle_start, rises 5 edges later.
   always @(posedge clk) begin
      mem_q <= deck[mem_addr];
      if (card_valid) cv_pulses <= cv_pulses + 1;
      if (shuffle_start) begin
         shuf_pulses  <= shuf_pulses + 1;
         shuffle_done <= 1'b0;
         shuf_cnt     <= 5;
      end else if (shuf_cnt > 0) begin
         shuf_cnt <= shuf_cnt - 1;
         if (shuf_cnt == 1) shuffle_done <= 1'b1;
      end
   end

   function automatic logic [3:0] card_at(input int a);
      return 4'((a + 7) % 16);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_card(input int budget, output bit ok);
      int n;
      n = 0;
      while (card_valid !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      ok = (card_valid === 1'b1);
   endtask

   task automatic do_reset(output bit ok);
      int n;
      rst_n = 1'b0; req_player = 1'b0; req_dealer = 1'b0; reshuffle = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      n = 1;
      while (busy === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      ok = (busy === 1'b0);
   endtask

   task automatic test_reset();
      int n;
      int sp0;
      rst_n = 1'b0; req_player = 1'b0; req_dealer = 1'b0; reshuffle = 1'b0;
      tick(); tick();
      vectors++; if (card_valid !== 1'b0) begin miscompares++; $display("FAIL rst_card_valid got %b want 0", card_valid); end
      vectors++; if (shuffle_start !== 1'b0) begin miscompares++; $display("FAIL rst_shuffle_start got %b want 0", shuffle_start); end
      vectors++; if (mem_addr !== '0) begin miscompares++; $display("FAIL rst_mem_addr got %0d want 0", mem_addr); end
      vectors++; if (card_value !== 4'd0 || card_dest !== 1'b0) begin miscompares++; $display("FAIL rst_card got value %0d dest %b want 0 0", card_value, card_dest); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
      sp0 = shuf_pulses;
      rst_n = 1'b1;
      tick();
      vectors++; if (shuffle_start !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL rel_shuffle got start %b busy %b want 1 1", shuffle_start, busy); end
      n = 1;
      while (busy === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      vectors++; if (n != 8) begin miscompares++; $display("FAIL shuffle_busy_cycles got %0d want 8", n); end
      vectors++; if (shuf_pulses - sp0 != 1) begin miscompares++; $display("FAIL shuffle_pulses got %0d want 1", shuf_pulses - sp0); end
      vectors++; if (cards_left !== AW'(DS)) begin miscompares++; $display("FAIL rel_cards_left got %0d want %0d", cards_left, DS); end
   endtask

   task automatic test_single_draw();
      bit ok;
      int n;
      do_reset(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL single_reset got busy %b want 0", busy); end
      req_player = 1'b1;
      tick();
      vectors++; if (busy !== 1'b1 || mem_addr !== '0 || card_valid !== 1'b0) begin miscompares++; $display("FAIL single_read got busy %b addr %0d cv %b want 1 0 0", busy, mem_addr, card_valid); end
      n = 1;
      while (card_valid !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      vectors++; if (n != 3) begin miscompares++; $display("FAIL single_latency got %0d want 3", n); end
      vectors++; if (card_value !== 4'd7 || card_dest !== DEST_PLAYER) begin miscompares++; $display("FAIL single_card got value %0d dest %b want 7 0", card_value, card_dest); end
      vectors++; if (cards_left !== AW'(DS - 1)) begin miscompares++; $display("FAIL single_cards_left got %0d want %0d", cards_left, DS - 1); end
      req_player = 1'b0;
      tick();
      vectors++; if (card_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL single_after got cv %b busy %b want 0 0", card_valid, busy); end
   endtask

   task automatic test_round_robin();
      bit ok;
      do_reset(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL rr_reset got busy %b want 0", busy); end
      req_player = 1'b1; req_dealer = 1'b1;
      for (int d = 0; d < 4; d++) begin
         wait_card(8, ok);
         vectors++; if (!ok) begin miscompares++; $display("FAIL rr_timeout draw %0d got cv %b want 1", d, card_valid); end
         vectors++; if (card_dest !== 1'(d % 2)) begin miscompares++; $display("FAIL rr_dest draw %0d got %b want %0d", d, card_dest, d % 2); end
         vectors++; if (mem_addr !== AW'(d) || card_value !== card_at(d)) begin miscompares++; $display("FAIL rr_addr draw %0d got addr %0d value %0d want %0d %0d", d, mem_addr, card_value, d, card_at(d)); end
         if (d == 3) begin req_player = 1'b0; req_dealer = 1'b0; end
         tick();
      end
   endtask

   task automatic test_reshuffle();
      bit ok;
      int sp0;
      do_reset(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL resh_reset got busy %b want 0", busy); end
      req_player = 1'b1;
      wait_card(8, ok);
      req_player = 1'b0;
      tick();
      sp0 = shuf_pulses;
      req_dealer = 1'b1; reshuffle = 1'b1;
      tick();
      reshuffle = 1'b0;
      vectors++; if (shuffle_start !== 1'b1) begin miscompares++; $display("FAIL resh_priority got start %b want 1", shuffle_start); end
      wait_card(30, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL resh_timeout got cv %b want 1", card_valid); end
      vectors++; if (card_dest !== DEST_DEALER || mem_addr !== '0 || card_value !== card_at(0)) begin miscompares++; $display("FAIL resh_card got dest %b addr %0d value %0d want 1 0 %0d", card_dest, mem_addr, card_value, card_at(0)); end
      vectors++; if (shuf_pulses - sp0 != 1) begin miscompares++; $display("FAIL resh_pulses got %0d want 1", shuf_pulses - sp0); end
      req_dealer = 1'b0;
      tick();
      req_player = 1'b1;
      tick();
      reshuffle = 1'b1;
      tick();
      reshuffle = 1'b0;
      wait_card(8, ok);
      vectors++; if (!ok || mem_addr !== AW'(1) || card_value !== card_at(1)) begin miscompares++; $display("FAIL resh_ignored_card got cv %b addr %0d value %0d want 1 1 %0d", card_valid, mem_addr, card_value, card_at(1)); end
      req_player = 1'b0;
      tick();
      vectors++; if (shuffle_start !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL resh_ignored got start %b busy %b want 0 0", shuffle_start, busy); end
   endtask

   task automatic test_wrap();
      bit ok;
      int n;
      do_reset(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL wrap_reset got busy %b want 0", busy); end
      req_player = 1'b1;
      for (int d = 0; d < DS; d++) begin
         wait_card(8, ok);
         vectors++; if (!ok || mem_addr !== AW'(d) || card_value !== card_at(d)) begin miscompares++; $display("FAIL wrap_draw %0d got cv %b addr %0d value %0d want 1 %0d %0d", d, card_valid, mem_addr, card_value, d, card_at(d)); end
         if (d == DS - 2) begin
            vectors++; if (cards_left !== AW'(1)) begin miscompares++; $display("FAIL wrap_last_left got %0d want 1", cards_left); end
         end
         if (d < DS - 1) tick();
      end
      vectors++; if (shuffle_start !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL wrap_shuffle got start %b busy %b want 1 1", shuffle_start, busy); end
      n = 0;
      do begin
         tick();
         n++;
      end while (card_valid !== 1'b1 && n < 30);
      vectors++; if (n != 10) begin miscompares++; $display("FAIL wrap_gap got %0d want 10", n); end
      vectors++; if (mem_addr !== '0 || card_value !== card_at(0) || shuffle_done !== 1'b1) begin miscompares++; $display("FAIL wrap_first got addr %0d value %0d done %b want 0 %0d 1", mem_addr, card_value, shuffle_done, card_at(0)); end
      req_player = 1'b0;
      tick();
   endtask

   task automatic test_reset_abort();
      bit ok;
      int cv0;
      do_reset(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL abort_reset got busy %b want 0", busy); end
      req_player = 1'b1;
      wait_card(8, ok);
      req_player = 1'b0;
      tick();
      cv0 = cv_pulses;
      req_dealer = 1'b1;
      tick();
      vectors++; if (busy !== 1'b1 || mem_addr !== AW'(1)) begin miscompares++; $display("FAIL abort_read got busy %b addr %0d want 1 1", busy, mem_addr); end
      rst_n = 1'b0;
      #1;
      req_dealer = 1'b0;
      vectors++; if (card_valid !== 1'b0 || shuffle_start !== 1'b0 || busy !== 1'b0 || mem_addr !== '0) begin miscompares++; $display("FAIL abort_ctrl got cv %b start %b busy %b addr %0d want 0 0 0 0", card_valid, shuffle_start, busy, mem_addr); end
      vectors++; if (card_value !== 4'd0 || card_dest !== 1'b0) begin miscompares++; $display("FAIL abort_card got value %0d dest %b want 0 0", card_value, card_dest); end
      tick(); tick(); tick();
      rst_n = 1'b1;
      tick();
      vectors++; if (shuffle_start !== 1'b1) begin miscompares++; $display("FAIL abort_reshuffle got %b want 1", shuffle_start); end
      for (int i = 0; i < 12; i++) tick();
      vectors++; if (cv_pulses != cv0 || busy !== 1'b0) begin miscompares++; $display("FAIL abort_no_card got pulses %0d busy %b want %0d 0", cv_pulses - cv0, busy, 0); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) deck[i] = card_at(i);
      test_reset();
      test_single_draw();
      test_round_robin();
      test_reshuffle();
      test_wrap();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
